// File: rtl/move_link_ctrl.sv
// rtl/move_link_ctrl.sv - move bus arbitration and stop-and-wait ACK/NAK link to the remote board
module move_link_ctrl #(
    parameter int                 PKT_LEN      = 8,
    parameter logic [PKT_LEN-1:0] ACK_CODE     = 8'hF0,
    parameter logic [PKT_LEN-1:0] NAK_CODE     = 8'hF1,
    parameter int                 TX_FRAME_CYC = 67_710,
    parameter int                 ACK_TIMEOUT  = 6_500_000,
    parameter int                 MAX_RETRY    = 3,
    parameter int                 VERDICT_CYC  = 16
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               my_turn,
    input  logic               local_valid,
    input  logic [PKT_LEN-1:0] local_move,
    input  logic               rx_valid,
    input  logic [PKT_LEN-1:0] rx_data,
    input  logic               fsm_accept,
    input  logic               fsm_reject,
    output logic               move_avail,
    output logic [PKT_LEN-1:0] move_out,
    output logic               tx_trigger,
    output logic [PKT_LEN-1:0] tx_data,
    output logic               busy,
    output logic               link_err
);

    localparam int GAP_W = $clog2(TX_FRAME_CYC + 1);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int VRD_W = $clog2(VERDICT_CYC + 1);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TX_FRAME_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(ACK_TIMEOUT);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [VRD_W-1:0] VRD_LAST = VRD_W'(VERDICT_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_L_APPLY,
        S_L_SEND,
        S_L_GAP,
        S_L_WAIT,
        S_R_APPLY,
        S_R_SEND,
        S_R_GAP,
        S_ERROR
    } state_t;

    state_t             state_q;
    logic [PKT_LEN-1:0] move_q;
    logic [PKT_LEN-1:0] reply_q;
    logic [PKT_LEN-1:0] last_rx_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [TO_W-1:0]    to_cnt_d;
    logic [RTY_W-1:0]   retry_q;
    logic [VRD_W-1:0]   vrd_cnt_q;
    logic               move_avail_q;
    logic [PKT_LEN-1:0] move_out_q;
    logic               tx_trigger_q;
    logic [PKT_LEN-1:0] tx_data_q;
    logic               busy_q;
    logic               link_err_q;

    logic rx_is_ctrl;
    logic rx_ack;
    logic rx_nak;

    assign rx_ack     = rx_valid && (rx_data == ACK_CODE);
    assign rx_nak     = rx_valid && (rx_data == NAK_CODE);
    assign rx_is_ctrl = (rx_data == ACK_CODE) || (rx_data == NAK_CODE);

    // Reply timeout counter: saturating increment so a long wait never wraps back to zero
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    // Link FSM with registered outputs; trigger and offer strobes default low each cycle
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= S_IDLE;
            move_q       <= '0;
            reply_q      <= '0;
            last_rx_q    <= '1;
            gap_cnt_q    <= '0;
            to_cnt_q     <= '0;
            retry_q      <= '0;
            vrd_cnt_q    <= '0;
            move_avail_q <= 1'b0;
            move_out_q   <= '0;
            tx_trigger_q <= 1'b0;
            tx_data_q    <= '0;
            busy_q       <= 1'b0;
            link_err_q   <= 1'b0;
        end else begin
            move_avail_q <= 1'b0;
            tx_trigger_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (my_turn && local_valid) begin
                        move_q       <= local_move;
                        move_out_q   <= local_move;
                        move_avail_q <= 1'b1;
                        vrd_cnt_q    <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= S_L_APPLY;
                    end else if (my_turn && rx_valid && (rx_data == last_rx_q)) begin
                        // Remote resent its move because our ACK was lost: re-ACK only
                        reply_q <= ACK_CODE;
                        busy_q  <= 1'b1;
                        state_q <= S_R_SEND;
                    end else if (!my_turn && rx_valid && !rx_is_ctrl) begin
                        move_q       <= rx_data;
                        move_out_q   <= rx_data;
                        move_avail_q <= 1'b1;
                        vrd_cnt_q    <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= S_R_APPLY;
                    end
                end
                S_L_APPLY: begin
                    if (fsm_reject) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (fsm_accept) begin
                        retry_q <= '0;
                        state_q <= S_L_SEND;
                    end else if (vrd_cnt_q == VRD_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        vrd_cnt_q <= vrd_cnt_q + VRD_W'(1);
                    end
                end
                S_L_SEND: begin
                    tx_trigger_q <= 1'b1;
                    tx_data_q    <= move_q;
                    to_cnt_q     <= '0;
                    gap_cnt_q    <= '0;
                    state_q      <= S_L_GAP;
                end
                S_L_GAP: begin
                    to_cnt_q <= to_cnt_d;
                    if (rx_ack) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (gap_cnt_q == GAP_LAST) begin
                        state_q <= S_L_WAIT;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                S_L_WAIT: begin
                    to_cnt_q <= to_cnt_d;
                    if (rx_ack) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (rx_nak) begin
                        busy_q     <= 1'b0;
                        link_err_q <= 1'b1;
                        state_q    <= S_ERROR;
                    end else if (to_cnt_q >= TO_LAST) begin
                        // Checked one cycle early so the resend lands ACK_TIMEOUT+1 after the last trigger
                        if (retry_q < RTY_MAX) begin
                            retry_q <= retry_q + RTY_W'(1);
                            state_q <= S_L_SEND;
                        end else begin
                            busy_q     <= 1'b0;
                            link_err_q <= 1'b1;
                            state_q    <= S_ERROR;
                        end
                    end
                end
                S_R_APPLY: begin
                    if (fsm_reject) begin
                        reply_q <= NAK_CODE;
                        state_q <= S_R_SEND;
                    end else if (fsm_accept) begin
                        last_rx_q <= move_q;
                        reply_q   <= ACK_CODE;
                        state_q   <= S_R_SEND;
                    end else if (vrd_cnt_q == VRD_LAST) begin
                        reply_q <= NAK_CODE;
                        state_q <= S_R_SEND;
                    end else begin
                        vrd_cnt_q <= vrd_cnt_q + VRD_W'(1);
                    end
                end
                S_R_SEND: begin
                    tx_trigger_q <= 1'b1;
                    tx_data_q    <= reply_q;
                    gap_cnt_q    <= '0;
                    state_q      <= S_R_GAP;
                end
                S_R_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                S_ERROR: begin
                    busy_q     <= 1'b0;
                    link_err_q <= 1'b1;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign move_avail = move_avail_q;
    assign move_out   = move_out_q;
    assign tx_trigger = tx_trigger_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign link_err   = link_err_q;

endmodule
